// File: rtl/ilb_interface_out.sv
`default_nettype none
// ============================================================================
//  Module   : ilb_interface_out
//  Purpose  : Transmit side of the ILB -> SoPU byte-window handshake. Six-byte
//             pixel windows pushed by the line-buffer logic are queued in a
//             small circular FIFO and offered one at a time to the SoPU using
//             the read_enable / rts / bytes_recieved protocol.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock, asynchronous active-high reset
//    win_push, win_byte_0..5   enqueue one window
//    win_full, win_empty       FIFO status (decoded from the occupancy count)
//    overflow                  sticky: a push was dropped because FIFO was full
//    ilb_read_enable           one-cycle pulse announcing the next window
//    sop_to_ilb_rts            ready-to-send; ilb_byte_* valid while high
//    bytes_recieved            SoPU acknowledge (level, may last many cycles)
//    ilb_byte_0..5             registered window bytes towards the SoPU
//    windows_sent              acknowledged-window counter, wraps at 2^16
// ============================================================================
module ilb_interface_out #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        win_push,
    input  logic [7:0]  win_byte_0,
    input  logic [7:0]  win_byte_1,
    input  logic [7:0]  win_byte_2,
    input  logic [7:0]  win_byte_3,
    input  logic [7:0]  win_byte_4,
    input  logic [7:0]  win_byte_5,
    output logic        win_full,
    output logic        win_empty,
    output logic        overflow,
    output logic        ilb_read_enable,
    output logic        sop_to_ilb_rts,
    input  logic        bytes_recieved,
    output logic [7:0]  ilb_byte_0,
    output logic [7:0]  ilb_byte_1,
    output logic [7:0]  ilb_byte_2,
    output logic [7:0]  ilb_byte_3,
    output logic [7:0]  ilb_byte_4,
    output logic [7:0]  ilb_byte_5,
    output logic [15:0] windows_sent
);

    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ANNOUNCE = 2'd1,
        S_SEND     = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t          state_q;
    logic [47:0]     mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            overflow_q;
    logic            read_enable_q;
    logic            rts_q;
    logic [47:0]     win_q;
    logic [15:0]     windows_sent_q;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_ok;

    assign w_full    = (count_q == CNT_FULL);
    assign w_empty   = (count_q == '0);
    // The acknowledge is only honoured in SEND; DRAIN swallows its tail so a
    // long acknowledge can never retire a second window.
    assign w_pop     = (state_q == S_SEND) && bytes_recieved;
    // A full FIFO still accepts a push when a slot frees up in the same cycle.
    assign w_push_ok = win_push && (!w_full || w_pop);

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Window storage: no reset needed, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {win_byte_5, win_byte_4, win_byte_3,
                                win_byte_2, win_byte_1, win_byte_0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (win_push && !w_push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            read_enable_q  <= 1'b0;
            rts_q          <= 1'b0;
            win_q          <= '0;
            windows_sent_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rts_q         <= 1'b0;
                    read_enable_q <= 1'b0;
                    if (!w_empty) begin
                        read_enable_q <= 1'b1;
                        state_q       <= S_ANNOUNCE;
                    end
                end
                S_ANNOUNCE: begin
                    read_enable_q <= 1'b0;
                    rts_q         <= 1'b1;
                    win_q         <= mem_q[rd_ptr_q];
                    state_q       <= S_SEND;
                end
                S_SEND: begin
                    if (bytes_recieved) begin
                        rts_q          <= 1'b0;
                        windows_sent_q <= windows_sent_q + 16'd1;
                        state_q        <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    rts_q <= 1'b0;
                    if (!bytes_recieved) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign win_full        = w_full;
    assign win_empty       = w_empty;
    assign overflow        = overflow_q;
    assign ilb_read_enable = read_enable_q;
    assign sop_to_ilb_rts  = rts_q;
    assign windows_sent    = windows_sent_q;
    assign ilb_byte_0      = win_q[7:0];
    assign ilb_byte_1      = win_q[15:8];
    assign ilb_byte_2      = win_q[23:16];
    assign ilb_byte_3      = win_q[31:24];
    assign ilb_byte_4      = win_q[39:32];
    assign ilb_byte_5      = win_q[47:40];

endmodule
`default_nettype wire

// File: tb/tb_ilb_interface_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ilb_interface_out
//  Purpose  : Self-checking bench for ilb_interface_out. Windows expected to
//             be accepted are queued when pushed and compared when the DUT
//             raises rts for them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ilb_interface_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        win_push = 1'b0;
    logic [7:0]  win_byte_0 = '0, win_byte_1 = '0, win_byte_2 = '0;
    logic [7:0]  win_byte_3 = '0, win_byte_4 = '0, win_byte_5 = '0;
    logic        win_full, win_empty, overflow;
    logic        ilb_read_enable, sop_to_ilb_rts;
    logic        bytes_recieved = 1'b0;
    logic [7:0]  ilb_byte_0, ilb_byte_1, ilb_byte_2;
    logic [7:0]  ilb_byte_3, ilb_byte_4, ilb_byte_5;
    logic [15:0] windows_sent;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] exp_q [$];
    logic        prev_rts = 1'b0;
    logic        prev_re  = 1'b0;

    always #5 clk = ~clk;

    ilb_interface_out #(.DEPTH(4), .AW(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .win_push        (win_push),
        .win_byte_0      (win_byte_0),
        .win_byte_1      (win_byte_1),
        .win_byte_2      (win_byte_2),
        .win_byte_3      (win_byte_3),
        .win_byte_4      (win_byte_4),
        .win_byte_5      (win_byte_5),
        .win_full        (win_full),
        .win_empty       (win_empty),
        .overflow        (overflow),
        .ilb_read_enable (ilb_read_enable),
        .sop_to_ilb_rts  (sop_to_ilb_rts),
        .bytes_recieved  (bytes_recieved),
        .ilb_byte_0      (ilb_byte_0),
        .ilb_byte_1      (ilb_byte_1),
        .ilb_byte_2      (ilb_byte_2),
        .ilb_byte_3      (ilb_byte_3),
        .ilb_byte_4      (ilb_byte_4),
        .ilb_byte_5      (ilb_byte_5),
        .windows_sent    (windows_sent)
    );

    function automatic logic [47:0] out_bytes();
        return {ilb_byte_5, ilb_byte_4, ilb_byte_3, ilb_byte_2, ilb_byte_1, ilb_byte_0};
    endfunction

    function automatic logic [47:0] mkwin(input logic [7:0] b);
        return {b + 8'd5, b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every rising rts delivers the oldest queued window;
    // read_enable must never be high two samples in a row.
    always @(negedge clk) begin
        if (sop_to_ilb_rts && !prev_rts) begin
            if (exp_q.size() == 0) check("unexpected_window", 64'(out_bytes()), 64'h0);
            else                   check("window", 64'(out_bytes()), 64'(exp_q.pop_front()));
        end
        if (prev_re) check("re_pulse", 64'(ilb_read_enable), 64'h0);
        prev_rts = sop_to_ilb_rts;
        prev_re  = ilb_read_enable;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_win(input logic [47:0] w);
        win_byte_0 = w[7:0];   win_byte_1 = w[15:8];  win_byte_2 = w[23:16];
        win_byte_3 = w[31:24]; win_byte_4 = w[39:32]; win_byte_5 = w[47:40];
    endtask

    task automatic push_win(input logic [47:0] w, input bit accept);
        win_push = 1'b1;
        drive_win(w);
        if (accept) exp_q.push_back(w);
        step();
        win_push = 1'b0;
    endtask

    task automatic wait_rts(input string tag);
        int k;
        k = 0;
        while (!sop_to_ilb_rts && k < 50) begin
            step();
            k++;
        end
        if (!sop_to_ilb_rts) check(tag, 64'h0, 64'h1);
    endtask

    task automatic ack(input int n);
        bytes_recieved = 1'b1;
        repeat (n) step();
        bytes_recieved = 1'b0;
    endtask

    initial begin
        // ---------------- reset state (asynchronous, before any edge)
        #1;
        check("rst_empty",    64'(win_empty), 64'h1);
        check("rst_full",     64'(win_full), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_re",       64'(ilb_read_enable), 64'h0);
        check("rst_rts",      64'(sop_to_ilb_rts), 64'h0);
        check("rst_bytes",    64'(out_bytes()), 64'h0);
        check("rst_sent",     64'(windows_sent), 64'h0);
        step();
        rst = 1'b0;
        step();

        // ---------------- single window latency and 2-cycle ack
        push_win(48'h060504030201, 1'b1);
        check("lat_n_empty", 64'(win_empty), 64'h0);
        check("lat_n_re",    64'(ilb_read_enable), 64'h0);
        step();
        check("lat_n1_re",   64'(ilb_read_enable), 64'h1);
        check("lat_n1_rts",  64'(sop_to_ilb_rts), 64'h0);
        step();
        check("lat_n2_rts",  64'(sop_to_ilb_rts), 64'h1);
        check("lat_n2_bytes", 64'(out_bytes()), 64'h060504030201);
        bytes_recieved = 1'b1;
        step();
        check("ack_rts",   64'(sop_to_ilb_rts), 64'h0);
        check("ack_sent",  64'(windows_sent), 64'h1);
        check("ack_empty", 64'(win_empty), 64'h1);
        step();
        bytes_recieved = 1'b0;
        repeat (3) step();
        check("idle_re",    64'(ilb_read_enable), 64'h0);
        check("hold_bytes", 64'(out_bytes()), 64'h060504030201);

        // ---------------- overflow: 5 pushes into DEPTH=4, no ack
        do_reset();
        for (int i = 0; i < 5; i++) begin
            win_push = 1'b1;
            drive_win(mkwin(8'(8'h10 + 8'(i * 8))));
            if (i < 4) exp_q.push_back(mkwin(8'(8'h10 + 8'(i * 8))));
            step();
            if (i == 3) begin
                check("ovf_full4", 64'(win_full), 64'h1);
                check("ovf_pre",   64'(overflow), 64'h0);
            end
        end
        win_push = 1'b0;
        check("ovf_set",   64'(overflow), 64'h1);
        check("ovf_full5", 64'(win_full), 64'h1);
        for (int i = 0; i < 4; i++) begin
            wait_rts("ovf_rts_timeout");
            ack(2);
        end
        repeat (8) step();
        check("ovf_sticky", 64'(overflow), 64'h1);
        check("ovf_sent",   64'(windows_sent), 64'h4);
        check("ovf_empty",  64'(win_empty), 64'h1);
        check("ovf_rts",    64'(sop_to_ilb_rts), 64'h0);

        // ---------------- push while full in the same cycle as an ack pop
        do_reset();
        for (int i = 0; i < 4; i++) push_win(mkwin(8'(8'h40 + 8'(i * 8))), 1'b1);
        wait_rts("pp_rts_timeout");
        check("pp_full_before", 64'(win_full), 64'h1);
        bytes_recieved = 1'b1;
        win_push = 1'b1;
        drive_win(mkwin(8'h80));
        exp_q.push_back(mkwin(8'h80));
        step();
        win_push = 1'b0;
        check("pp_full_after", 64'(win_full), 64'h1);
        check("pp_overflow",   64'(overflow), 64'h0);
        check("pp_sent",       64'(windows_sent), 64'h1);
        step();
        bytes_recieved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_rts("pp_drain_timeout");
            ack(2);
        end
        repeat (4) step();
        check("pp_sent_end", 64'(windows_sent), 64'h5);
        check("pp_empty",    64'(win_empty), 64'h1);

        // ---------------- long acknowledge retires only one window
        do_reset();
        push_win(mkwin(8'hA0), 1'b1);
        push_win(mkwin(8'hB0), 1'b1);
        wait_rts("long_rts_timeout");
        bytes_recieved = 1'b1;
        step();
        check("long_rts0",  64'(sop_to_ilb_rts), 64'h0);
        check("long_sent0", 64'(windows_sent), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("long_rts",  64'(sop_to_ilb_rts), 64'h0);
            check("long_re",   64'(ilb_read_enable), 64'h0);
            check("long_sent", 64'(windows_sent), 64'h1);
        end
        bytes_recieved = 1'b0;
        step();
        check("long_drop_re0", 64'(ilb_read_enable), 64'h0);
        step();
        check("long_drop_re1", 64'(ilb_read_enable), 64'h1);
        wait_rts("long_rts2_timeout");
        ack(2);
        step();
        check("long_sent_end", 64'(windows_sent), 64'h2);

        // ---------------- withheld ack, then asynchronous reset mid-SEND
        do_reset();
        push_win(mkwin(8'hC0), 1'b1);
        wait_rts("stall_rts_timeout");
        for (int i = 0; i < 100; i++) begin
            step();
            check("stall_rts",   64'(sop_to_ilb_rts), 64'h1);
            check("stall_bytes", 64'(out_bytes()), 64'(mkwin(8'hC0)));
        end
        #2 rst = 1'b1;
        #1;
        check("arst_rts",   64'(sop_to_ilb_rts), 64'h0);
        check("arst_re",    64'(ilb_read_enable), 64'h0);
        check("arst_bytes", 64'(out_bytes()), 64'h0);
        check("arst_empty", 64'(win_empty), 64'h1);
        check("arst_sent",  64'(windows_sent), 64'h0);
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (4) step();
        check("arst_no_resend", 64'(sop_to_ilb_rts), 64'h0);

        // ---------------- windows_sent wraps at 16 bits
        do_reset();
        force dut.windows_sent_q = 16'hFFFF;
        step();
        release dut.windows_sent_q;
        step();
        check("wrap_pre", 64'(windows_sent), 64'hFFFF);
        push_win(mkwin(8'hE0), 1'b1);
        wait_rts("wrap_rts_timeout");
        ack(2);
        step();
        check("wrap_post", 64'(windows_sent), 64'h0);

        repeat (4) step();
        check("scoreboard_left", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
